// File: rtl/rriot_pkg.sv
// Shared types and constants for the RRIOT port front end.
// Idle port level, default debounce window and the 8-bit port type.
package rriot_pkg;

    typedef logic [7:0] port_t;

    localparam port_t PORT_IDLE        = 8'hFF;
    localparam int    DEBOUNCE_DEFAULT = 16;

endpackage

// File: rtl/rriot_port_conditioner_if.sv
// Pin, debounced-port and edge/IRQ bundle of the port conditioner.
// master drives pins and controls; slave is the conditioner itself.
interface rriot_port_conditioner_if;
    import rriot_pkg::*;

    port_t pa_pin;
    port_t pb_pin;
    port_t pai;
    port_t pbi;
    port_t pa_changed;
    port_t pb_changed;
    logic  edge_sel;
    logic  edge_irq_en;
    logic  edge_ack;
    logic  edge_flag;
    logic  irq_n;

    modport master (
        output pa_pin, pb_pin, edge_sel, edge_irq_en, edge_ack,
        input  pai, pbi, pa_changed, pb_changed, edge_flag, irq_n
    );

    modport slave (
        input  pa_pin, pb_pin, edge_sel, edge_irq_en, edge_ack,
        output pai, pbi, pa_changed, pb_changed, edge_flag, irq_n
    );

endinterface

// File: rtl/port_debounce.sv
// One pin: two-flop synchroniser, debounce counter, stable level
// and a one-cycle pulse whenever the accepted level changes.
module port_debounce #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_VAL       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] count;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
        end else begin
            s1 <= pin;
            s2 <= s1;
        end
    end

    // Accept a new level only after an unbroken run of differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            level   <= RESET_VAL;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (s2 == level) begin
                count <= '0;
            end else if (count == LAST) begin
                level   <= s2;
                count   <= '0;
                changed <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rriot_port_conditioner.sv
// RRIOT port input front end: sync + debounce of PA/PB and a
// PA edge detector with latched flag and active-low interrupt.
module rriot_port_conditioner
    import rriot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int EDGE_PIN        = 7
) (
    input logic phi2,
    input logic rst,
    rriot_port_conditioner_if.slave bus
);

    port_t pai_int;
    port_t pbi_int;
    port_t pa_chg;
    port_t pb_chg;
    logic  edge_set;
    logic  flag_q;
    logic  flag_d;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        port_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (PORT_IDLE[i])
        ) u_pa (
            .clk    (phi2),
            .rst    (rst),
            .pin    (bus.pa_pin[i]),
            .level  (pai_int[i]),
            .changed(pa_chg[i])
        );

        port_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (PORT_IDLE[i])
        ) u_pb (
            .clk    (phi2),
            .rst    (rst),
            .pin    (bus.pb_pin[i]),
            .level  (pbi_int[i]),
            .changed(pb_chg[i])
        );
    end

    // A debounced change to the selected polarity sets the flag; set beats ack.
    always_comb begin
        edge_set = 1'b0;
        flag_d   = flag_q;
        edge_set = pa_chg[EDGE_PIN] && (pai_int[EDGE_PIN] == bus.edge_sel);
        flag_d   = edge_set || (flag_q && !bus.edge_ack);
    end

    // Latched edge flag, held until acknowledged.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign bus.pai        = pai_int;
    assign bus.pbi        = pbi_int;
    assign bus.pa_changed = pa_chg;
    assign bus.pb_changed = pb_chg;
    assign bus.edge_flag  = flag_q;
    assign bus.irq_n      = ~(flag_q & bus.edge_irq_en);

endmodule

// File: tb/tb_rriot_port_conditioner.sv
// Directed bench for rriot_port_conditioner with a FIFO scoreboard
// of expected values checked by immediate assertions.
module tb_rriot_port_conditioner;
    import rriot_pkg::*;

    logic phi2;
    logic rst;

    rriot_port_conditioner_if bus ();

    rriot_port_conditioner #(
        .DEBOUNCE_CYCLES(16),
        .EDGE_PIN       (7)
    ) dut (
        .phi2(phi2),
        .rst (rst),
        .bus (bus)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_empty observed=%0h expected=entry", obs);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(negedge phi2);
    endtask

    task automatic wait_pa_change(input int b, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (bus.pa_changed[b]) seen = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] acc;
        logic       seen;

        rst             = 1'b1;
        bus.pa_pin      = 8'hFF;
        bus.pb_pin      = 8'hFF;
        bus.edge_sel    = 1'b0;
        bus.edge_irq_en = 1'b0;
        bus.edge_ack    = 1'b0;
        repeat (3) step();

        push("rst_pai", 8'hFF);
        push("rst_pbi", 8'hFF);
        push("rst_flag", 1'b0);
        push("rst_irq_n", 1'b1);
        pop_check(bus.pai);
        pop_check(bus.pbi);
        pop_check(bus.edge_flag);
        pop_check(bus.irq_n);

        rst = 1'b0;
        acc = 8'h00;
        push("idle_no_pulse", 8'h00);
        for (int i = 0; i < 20; i++) begin
            step();
            acc = acc | bus.pa_changed | bus.pb_changed;
        end
        pop_check(acc);

        bus.pa_pin[3] = 1'b0;
        push("lat_pai_17", 8'hFF);
        push("lat_no_early_pulse", 8'h00);
        push("lat_pai_18", 8'hF7);
        push("lat_pulse", 8'h08);
        push("lat_pulse_end", 8'h00);
        acc = 8'h00;
        for (int i = 0; i < 17; i++) begin
            step();
            acc = acc | bus.pa_changed;
        end
        pop_check(bus.pai);
        pop_check(acc);
        step();
        pop_check(bus.pai);
        pop_check(bus.pa_changed);
        step();
        pop_check(bus.pa_changed);

        bus.pb_pin[0] = 1'b0;
        push("glitch_pbi", 8'hFF);
        push("glitch_no_pulse", 8'h00);
        acc = 8'h00;
        for (int i = 0; i < 15; i++) begin
            step();
            acc = acc | bus.pb_changed;
        end
        bus.pb_pin[0] = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            acc = acc | bus.pb_changed;
        end
        pop_check(bus.pbi);
        pop_check(acc);

        bus.edge_sel    = 1'b0;
        bus.edge_irq_en = 1'b1;
        bus.pa_pin[7]   = 1'b0;
        push("fall_seen", 1'b1);
        push("fall_flag_same_cycle", 1'b0);
        push("fall_flag", 1'b1);
        push("fall_irq_n", 1'b0);
        push("ack_flag", 1'b0);
        push("ack_irq_n", 1'b1);
        wait_pa_change(7, seen);
        pop_check(seen);
        pop_check(bus.edge_flag);
        step();
        pop_check(bus.edge_flag);
        pop_check(bus.irq_n);
        bus.edge_ack = 1'b1;
        step();
        bus.edge_ack = 1'b0;
        pop_check(bus.edge_flag);
        pop_check(bus.irq_n);

        bus.edge_sel = 1'b1;
        push("sel_only_flag", 1'b0);
        repeat (3) step();
        pop_check(bus.edge_flag);

        bus.pa_pin[7] = 1'b1;
        push("rise1_seen", 1'b1);
        push("rise1_flag", 1'b1);
        push("rise1_ack", 1'b0);
        wait_pa_change(7, seen);
        pop_check(seen);
        step();
        pop_check(bus.edge_flag);
        bus.edge_ack = 1'b1;
        step();
        bus.edge_ack = 1'b0;
        pop_check(bus.edge_flag);

        bus.pa_pin[7] = 1'b0;
        push("sel1_fall_seen", 1'b1);
        push("sel1_fall_flag", 1'b0);
        wait_pa_change(7, seen);
        pop_check(seen);
        repeat (2) step();
        pop_check(bus.edge_flag);

        bus.pa_pin[7] = 1'b1;
        push("rise2_seen", 1'b1);
        push("rise2_flag", 1'b1);
        push("rise2_ack", 1'b0);
        wait_pa_change(7, seen);
        pop_check(seen);
        step();
        pop_check(bus.edge_flag);
        bus.edge_ack = 1'b1;
        step();
        bus.edge_ack = 1'b0;
        pop_check(bus.edge_flag);

        push("sel_toggle_flag", 1'b0);
        bus.edge_sel = 1'b0;
        step();
        bus.edge_sel = 1'b1;
        step();
        bus.edge_sel = 1'b0;
        step();
        pop_check(bus.edge_flag);

        bus.pa_pin[7] = 1'b0;
        push("coll_seen", 1'b1);
        push("coll_flag", 1'b1);
        push("coll_irq_n", 1'b0);
        push("irq_dis_irq_n", 1'b1);
        push("irq_dis_flag", 1'b1);
        push("irq_en_irq_n", 1'b0);
        wait_pa_change(7, seen);
        pop_check(seen);
        bus.edge_ack = 1'b1;
        step();
        bus.edge_ack = 1'b0;
        pop_check(bus.edge_flag);
        pop_check(bus.irq_n);
        bus.edge_irq_en = 1'b0;
        #1;
        pop_check(bus.irq_n);
        pop_check(bus.edge_flag);
        bus.edge_irq_en = 1'b1;
        #1;
        pop_check(bus.irq_n);

        @(posedge phi2);
        #2;
        rst = 1'b1;
        #1;
        push("mrst_pai", 8'hFF);
        push("mrst_pbi", 8'hFF);
        push("mrst_flag", 1'b0);
        push("mrst_irq_n", 1'b1);
        pop_check(bus.pai);
        pop_check(bus.pbi);
        pop_check(bus.edge_flag);
        pop_check(bus.irq_n);
        step();
        rst = 1'b0;

        push("requal_pai_17", 8'hFF);
        push("requal_no_early_pulse", 8'h00);
        push("requal_pai_18", 8'h77);
        push("requal_pulse", 8'h88);
        push("requal_flag", 1'b1);
        acc = 8'h00;
        for (int i = 0; i < 17; i++) begin
            step();
            acc = acc | bus.pa_changed | bus.pb_changed;
        end
        pop_check(bus.pai);
        pop_check(acc);
        step();
        pop_check(bus.pai);
        pop_check(bus.pa_changed);
        step();
        pop_check(bus.edge_flag);

        push("sb_drained", 32'd0);
        pop_check(32'(sb.size() - 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
